vend_customer_driver: RTL and testbench
=======================================

# vend_customer_driver

Customer-side front end for the vending machine controller. It accepts a purchase request (item number 0–19 and card balance) from the panel or bench, then plays the customer end of the vend protocol:
- card insertion;
- two-digit key entry;
- reading the quoted cost;
- payment authorisation;
- door open/close.

It returns one status response per request. It sits between the user panel logic and the vending machine, driving every machine input except CLK, RELOAD and the machine's own reset.

## Interface
- TIMEOUT_CYCLES, 16: max cycles to wait for any machine response before aborting with TIMEOUT.
- DOOR_CYCLES, 3: cycles DOOR_OPEN is held high after VEND is seen.

- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  high only in IDLE.
- REQ_ITEM  in  5  item number, valid 0–19.
- REQ_BALANCE  in  8  card balance.
- RSP_VALID  out  1  one-cycle response strobe.
- RSP_STATUS  out  2  response code: 0 OK, 1 INVALID, 2 DECLINED, 3 TIMEOUT.
- RSP_COST  out  3  cost quoted by the machine, 0 if none.
- RSP_BALANCE  out  8  balance after purchase; unchanged unless status is OK.
- CARD_IN, KEY_PRESS, VALID_TRAN, DOOR_OPEN  out  1 each  to the machine.
- ITEM_CODE  out  4  to the machine.
- VEND, INVALID_SEL, FAILED_TRAN  in  1 each  from the machine.
- COST  in  3  from the machine.

## Operation
States: IDLE, CARD, KEY1, GAP, KEY2, WAIT_COST, PAY, WAIT_FAIL, DOOR, DONE.

- **IDLE**
  - REQ_READY=1.
  - On REQ_VALID, latch item and balance.
  - If the item is greater than 19, go straight to DONE with INVALID; no machine traffic.
  - Otherwise go to CARD.
- **CARD:** CARD_IN=1 for exactly one cycle.
- **KEY1:** ITEM_CODE=tens digit (item/10), KEY_PRESS=1 for one cycle.
- **GAP:** KEY_PRESS=0, ITEM_CODE held.
- **KEY2:** ITEM_CODE=ones digit (item%10), KEY_PRESS=1 for one cycle.
- **Cost decision**
  - INVALID_SEL and COST are sampled in KEY2 and in every WAIT_COST cycle.
  - The first cycle with INVALID_SEL=1 or COST≠0 decides the outcome.
  - INVALID_SEL=1 takes priority over a simultaneous COST → DONE/INVALID.
  - COST≠0 and balance≥COST → latch cost, go to PAY.
  - COST≠0 and balance<COST → latch cost, go to WAIT_FAIL.
- **PAY:** VALID_TRAN=1, held until VEND=1, then go to DOOR.
- **WAIT_FAIL:** VALID_TRAN=0; FAILED_TRAN=1 → DONE/DECLINED.
- **DOOR:**
  - Balance ← balance − cost: 8-bit unsigned, cannot underflow because it was checked.
  - DOOR_OPEN=1 for DOOR_CYCLES cycles, then 0.
  - Wait for VEND=0, then DONE/OK.
- **DONE:** RSP_VALID=1 for one cycle with status, cost and balance; then return to IDLE.
- **Timeout:** one shared timer is reloaded on entry to each of WAIT_COST, PAY, WAIT_FAIL and DOOR. If it expires before the exit condition, all machine outputs go to 0 and the block goes to DONE/TIMEOUT.
- **Reset**
  - Reset value of every output is 0, including ITEM_CODE, RSP_* and REQ_READY; state is IDLE.
  - REQ_READY rises on the first cycle after reset is released.
  - Reset asserted mid-transaction aborts it with no response.

## Timing
- Request is accepted on cycle 0 (REQ_VALID·REQ_READY).
- CARD_IN is high on cycle 1, KEY_PRESS on cycles 2 and 4; ITEM_CODE is stable cycles 2–4.
- Earliest decision: cycle 4.
- All outputs are registered; no combinational path from machine inputs to machine outputs.
- PAY → DOOR one cycle after VEND is sampled high; VALID_TRAN drops the same edge DOOR_OPEN rises.
- Out-of-range item: RSP_VALID on cycle 2.
- Back-to-back requests: REQ_READY is high the cycle after RSP_VALID.

## Structure
- Shared package vend_pkg holds:
  - the state enum;
  - the RSP_STATUS codes (OK, INVALID, DECLINED, TIMEOUT);
  - item-range constant 19 and widths: item 5, code 4, cost 3, balance 8.
- Sub-module vend_timer: loadable down-counter with an expired flag, sized by clog2(TIMEOUT_CYCLES+1), reused for the DOOR_CYCLES count.

## Test plan
- Item 12, balance 10; machine returns COST=4 on KEY2 and VEND two cycles after VALID_TRAN → ITEM_CODE 1 then 2; DOOR_OPEN high 3 cycles; RSP status 0, cost 4, balance 6.
- Item 7, balance 1; COST=2 → VALID_TRAN never asserted; FAILED_TRAN after 5 cycles → status 2, balance 1.
- Item 3; INVALID_SEL=1 together with COST=1 in KEY2 → status 1, cost 0, no VALID_TRAN.
- Item 25 → no CARD_IN or KEY_PRESS; RSP_VALID on cycle 2 with status 1.
- Item 5; machine silent → TIMEOUT_CYCLES after KEY2, status 3, all machine outputs 0.
- RST_N low during PAY → next cycle all outputs 0, no RSP_VALID; a fresh request then completes normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending customer driver.
package vend_pkg;

    localparam int ITEM_W = 5;
    localparam int CODE_W = 4;
    localparam int COST_W = 3;
    localparam int BAL_W  = 8;

    localparam logic [ITEM_W-1:0] ITEM_MAX = 5'd19;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CARD,
        S_KEY1,
        S_GAP,
        S_KEY2,
        S_WAIT_COST,
        S_PAY,
        S_WAIT_FAIL,
        S_DOOR,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_INVALID  = 2'd1,
        RSP_DECLINED = 2'd2,
        RSP_TIMEOUT  = 2'd3
    } rsp_status_e;

    // Digit split only needs to cover the legal range 0..19.
    function automatic logic [CODE_W-1:0] tens_digit(input logic [ITEM_W-1:0] item);
        return (item >= 5'd10) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [CODE_W-1:0] ones_digit(input logic [ITEM_W-1:0] item);
        logic [ITEM_W-1:0] v;
        v = (item >= 5'd10) ? (item - 5'd10) : item;
        return v[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/vend_customer_driver_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module vend_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/vend_customer_driver.sv
// Customer-side driver: plays card/key/pay/door protocol against the
// vending machine for one request and returns a single status response.
module vend_customer_driver
    import vend_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DOOR_CYCLES    = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ITEM_W-1:0] REQ_ITEM,
    input  logic [BAL_W-1:0]  REQ_BALANCE,
    output logic              RSP_VALID,
    output logic [1:0]        RSP_STATUS,
    output logic [COST_W-1:0] RSP_COST,
    output logic [BAL_W-1:0]  RSP_BALANCE,
    output logic              CARD_IN,
    output logic              KEY_PRESS,
    output logic              VALID_TRAN,
    output logic              DOOR_OPEN,
    output logic [CODE_W-1:0] ITEM_CODE,
    input  logic              VEND,
    input  logic              INVALID_SEL,
    input  logic              FAILED_TRAN,
    input  logic [COST_W-1:0] COST
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e            r_state, w_state_nxt;
    rsp_status_e       r_status, w_status_nxt;
    logic [ITEM_W-1:0] r_item, w_item_nxt;
    logic [BAL_W-1:0]  r_bal, w_bal_nxt;
    logic [COST_W-1:0] r_cost, w_cost_nxt;

    logic              r_ready, r_rsp_valid;
    logic [1:0]        r_rsp_status;
    logic [COST_W-1:0] r_rsp_cost;
    logic [BAL_W-1:0]  r_rsp_bal;
    logic              r_card, r_key, r_vtran, r_door;
    logic [CODE_W-1:0] r_code;

    logic w_to_load, w_to_exp, w_door_load, w_door_exp;
    logic [BAL_W-1:0] w_cost_ext;

    assign w_cost_ext = {{(BAL_W-COST_W){1'b0}}, COST};

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_item_nxt   = r_item;
        w_bal_nxt    = r_bal;
        w_cost_nxt   = r_cost;
        unique case (r_state)
            S_IDLE: begin
                if (REQ_VALID && r_ready) begin
                    w_item_nxt = REQ_ITEM;
                    w_bal_nxt  = REQ_BALANCE;
                    w_cost_nxt = '0;
                    if (REQ_ITEM > ITEM_MAX) begin
                        w_status_nxt = RSP_INVALID;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_state_nxt = S_CARD;
                    end
                end
            end
            S_CARD: w_state_nxt = S_KEY1;
            S_KEY1: w_state_nxt = S_GAP;
            S_GAP:  w_state_nxt = S_KEY2;
            S_KEY2, S_WAIT_COST: begin
                if (INVALID_SEL) begin
                    w_status_nxt = RSP_INVALID;
                    w_state_nxt  = S_DONE;
                end else if (COST != '0) begin
                    w_cost_nxt  = COST;
                    w_state_nxt = (r_bal >= w_cost_ext) ? S_PAY : S_WAIT_FAIL;
                end else if (r_state == S_KEY2) begin
                    w_state_nxt = S_WAIT_COST;
                end else if (w_to_exp) begin
                    w_status_nxt = RSP_TIMEOUT;
                    w_state_nxt  = S_DONE;
                end
            end
            S_PAY: begin
                if (VEND) begin
                    w_state_nxt = S_DOOR;
                end else if (w_to_exp) begin
                    w_status_nxt = RSP_TIMEOUT;
                    w_state_nxt  = S_DONE;
                end
            end
            S_WAIT_FAIL: begin
                if (FAILED_TRAN) begin
                    w_status_nxt = RSP_DECLINED;
                    w_state_nxt  = S_DONE;
                end else if (w_to_exp) begin
                    w_status_nxt = RSP_TIMEOUT;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DOOR: begin
                // Balance is only debited once the door cycle completes cleanly.
                if (w_door_exp && !VEND) begin
                    w_bal_nxt    = r_bal - {{(BAL_W-COST_W){1'b0}}, r_cost};
                    w_status_nxt = RSP_OK;
                    w_state_nxt  = S_DONE;
                end else if (w_to_exp) begin
                    w_status_nxt = RSP_TIMEOUT;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_to_load = (w_state_nxt != r_state) &&
                       (w_state_nxt == S_WAIT_COST || w_state_nxt == S_PAY ||
                        w_state_nxt == S_WAIT_FAIL || w_state_nxt == S_DOOR);
    assign w_door_load = (w_state_nxt == S_DOOR) && (r_state != S_DOOR);

    vend_timer #(.W(TW)) u_to_timer (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_load    (w_to_load),
        .i_value   (TW'(TIMEOUT_CYCLES - 1)),
        .o_expired (w_to_exp)
    );

    vend_timer #(.W(TW)) u_door_timer (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_load    (w_door_load),
        .i_value   (TW'(DOOR_CYCLES - 1)),
        .o_expired (w_door_exp)
    );

    // Machine outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_status     <= RSP_OK;
            r_item       <= '0;
            r_bal        <= '0;
            r_cost       <= '0;
            r_ready      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= '0;
            r_rsp_cost   <= '0;
            r_rsp_bal    <= '0;
            r_card       <= 1'b0;
            r_key        <= 1'b0;
            r_vtran      <= 1'b0;
            r_door       <= 1'b0;
            r_code       <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_item   <= w_item_nxt;
            r_bal    <= w_bal_nxt;
            r_cost   <= w_cost_nxt;
            r_ready  <= (r_state == S_IDLE) && (w_state_nxt == S_IDLE);
            r_card   <= (w_state_nxt == S_CARD);
            r_key    <= (w_state_nxt == S_KEY1) || (w_state_nxt == S_KEY2);
            r_vtran  <= (w_state_nxt == S_PAY);
            r_door   <= (w_state_nxt == S_DOOR) &&
                        ((r_state != S_DOOR) || !w_door_exp);
            if (w_state_nxt == S_KEY1) begin
                r_code <= tens_digit(r_item);
            end else if (w_state_nxt == S_KEY2) begin
                r_code <= ones_digit(r_item);
            end else if (w_state_nxt != S_GAP) begin
                r_code <= '0;
            end
            r_rsp_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_rsp_status <= r_status;
                r_rsp_cost   <= r_cost;
                r_rsp_bal    <= r_bal;
            end
        end
    end

    assign REQ_READY   = r_ready;
    assign RSP_VALID   = r_rsp_valid;
    assign RSP_STATUS  = r_rsp_status;
    assign RSP_COST    = r_rsp_cost;
    assign RSP_BALANCE = r_rsp_bal;
    assign CARD_IN     = r_card;
    assign KEY_PRESS   = r_key;
    assign VALID_TRAN  = r_vtran;
    assign DOOR_OPEN   = r_door;
    assign ITEM_CODE   = r_code;

endmodule

// File: tb/tb_vend_customer_driver.sv
// Directed bench for vend_customer_driver with immediate-assertion checks.
module tb_vend_customer_driver;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [4:0] REQ_ITEM;
    logic [7:0] REQ_BALANCE;
    logic       RSP_VALID;
    logic [1:0] RSP_STATUS;
    logic [2:0] RSP_COST;
    logic [7:0] RSP_BALANCE;
    logic       CARD_IN, KEY_PRESS, VALID_TRAN, DOOR_OPEN;
    logic [3:0] ITEM_CODE;
    logic       VEND, INVALID_SEL, FAILED_TRAN;
    logic [2:0] COST;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    vend_customer_driver #(.TIMEOUT_CYCLES(16), .DOOR_CYCLES(3)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_ITEM    (REQ_ITEM),
        .REQ_BALANCE (REQ_BALANCE),
        .RSP_VALID   (RSP_VALID),
        .RSP_STATUS  (RSP_STATUS),
        .RSP_COST    (RSP_COST),
        .RSP_BALANCE (RSP_BALANCE),
        .CARD_IN     (CARD_IN),
        .KEY_PRESS   (KEY_PRESS),
        .VALID_TRAN  (VALID_TRAN),
        .DOOR_OPEN   (DOOR_OPEN),
        .ITEM_CODE   (ITEM_CODE),
        .VEND        (VEND),
        .INVALID_SEL (INVALID_SEL),
        .FAILED_TRAN (FAILED_TRAN),
        .COST        (COST)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, " card"}, 32'(CARD_IN), 0);
        chk({tag, " key"}, 32'(KEY_PRESS), 0);
        chk({tag, " vtran"}, 32'(VALID_TRAN), 0);
        chk({tag, " door"}, 32'(DOOR_OPEN), 0);
        chk({tag, " code"}, 32'(ITEM_CODE), 0);
    endtask

    task automatic rsp(input string tag, input int st, input int cost, input int bal);
        chk({tag, " rsp_valid"}, 32'(RSP_VALID), 1);
        chk({tag, " status"}, 32'(RSP_STATUS), 32'(st));
        chk({tag, " cost"}, 32'(RSP_COST), 32'(cost));
        chk({tag, " bal"}, 32'(RSP_BALANCE), 32'(bal));
    endtask

    // Cycle 0: present request; returns in cycle 1.
    task automatic request(input string tag, input int item, input int bal);
        chk({tag, " ready"}, 32'(REQ_READY), 1);
        REQ_VALID   = 1'b1;
        REQ_ITEM    = 5'(item);
        REQ_BALANCE = 8'(bal);
        tick();
        REQ_VALID = 1'b0;
        chk({tag, " ready_low"}, 32'(REQ_READY), 0);
    endtask

    // From cycle 1 through cycle 4 (KEY2), checking card and key traffic.
    task automatic keys(input string tag, input int tens, input int ones);
        chk({tag, " card_c1"}, 32'(CARD_IN), 1);
        tick();
        chk({tag, " key_c2"}, 32'(KEY_PRESS), 1);
        chk({tag, " code_c2"}, 32'(ITEM_CODE), 32'(tens));
        chk({tag, " card_c2"}, 32'(CARD_IN), 0);
        tick();
        chk({tag, " key_c3"}, 32'(KEY_PRESS), 0);
        chk({tag, " code_c3"}, 32'(ITEM_CODE), 32'(tens));
        tick();
        chk({tag, " key_c4"}, 32'(KEY_PRESS), 1);
        chk({tag, " code_c4"}, 32'(ITEM_CODE), 32'(ones));
    endtask

    initial begin
        RST_N = 1'b0;
        REQ_VALID = 1'b0;
        REQ_ITEM = '0;
        REQ_BALANCE = '0;
        VEND = 1'b0;
        INVALID_SEL = 1'b0;
        FAILED_TRAN = 1'b0;
        COST = '0;

        tick();
        tick();
        outs_zero("reset");
        chk("reset ready", 32'(REQ_READY), 0);
        chk("reset rsp_valid", 32'(RSP_VALID), 0);
        chk("reset status", 32'(RSP_STATUS), 0);
        chk("reset cost", 32'(RSP_COST), 0);
        chk("reset bal", 32'(RSP_BALANCE), 0);
        RST_N = 1'b1;
        tick();
        chk("post_reset ready", 32'(REQ_READY), 1);

        // Item 12, balance 10, cost 4, VEND two cycles after VALID_TRAN.
        request("ok", 12, 10);
        keys("ok", 1, 2);
        COST = 3'd4;
        tick();
        COST = '0;
        chk("ok vtran_c5", 32'(VALID_TRAN), 1);
        chk("ok key_c5", 32'(KEY_PRESS), 0);
        tick();
        chk("ok vtran_c6", 32'(VALID_TRAN), 1);
        tick();
        VEND = 1'b1;
        chk("ok vtran_c7", 32'(VALID_TRAN), 1);
        chk("ok door_c7", 32'(DOOR_OPEN), 0);
        tick();
        chk("ok vtran_c8", 32'(VALID_TRAN), 0);
        chk("ok door_c8", 32'(DOOR_OPEN), 1);
        tick();
        VEND = 1'b0;
        chk("ok door_c9", 32'(DOOR_OPEN), 1);
        tick();
        chk("ok door_c10", 32'(DOOR_OPEN), 1);
        tick();
        chk("ok door_c11", 32'(DOOR_OPEN), 0);
        chk("ok rsp_c11", 32'(RSP_VALID), 0);
        tick();
        rsp("ok", 0, 4, 6);
        tick();
        chk("ok rsp_c13", 32'(RSP_VALID), 0);

        // Item 7, balance 1, cost 2: declined.
        request("dec", 7, 1);
        keys("dec", 0, 7);
        COST = 3'd2;
        tick();
        COST = '0;
        for (int c = 5; c < 9; c++) begin
            chk("dec vtran", 32'(VALID_TRAN), 0);
            tick();
        end
        FAILED_TRAN = 1'b1;
        chk("dec vtran_c9", 32'(VALID_TRAN), 0);
        tick();
        FAILED_TRAN = 1'b0;
        chk("dec rsp_c10", 32'(RSP_VALID), 0);
        tick();
        rsp("dec", 2, 2, 1);
        tick();

        // Item 3, INVALID_SEL wins over COST in KEY2.
        request("inv", 3, 9);
        keys("inv", 0, 3);
        INVALID_SEL = 1'b1;
        COST = 3'd1;
        tick();
        INVALID_SEL = 1'b0;
        COST = '0;
        chk("inv vtran_c5", 32'(VALID_TRAN), 0);
        tick();
        rsp("inv", 1, 0, 9);
        tick();

        // Item 25: no machine traffic, response on cycle 2.
        request("oor", 25, 50);
        chk("oor card_c1", 32'(CARD_IN), 0);
        chk("oor rsp_c1", 32'(RSP_VALID), 0);
        tick();
        rsp("oor", 1, 0, 50);
        chk("oor key_c2", 32'(KEY_PRESS), 0);
        tick();

        // Item 5, machine silent: timeout.
        request("to", 5, 20);
        keys("to", 0, 5);
        tick();
        for (int c = 5; c < 22; c++) begin
            chk("to rsp_early", 32'(RSP_VALID), 0);
            chk("to vtran", 32'(VALID_TRAN), 0);
            tick();
        end
        rsp("to", 3, 0, 20);
        outs_zero("to");
        tick();

        // Reset during PAY aborts with no response.
        request("rst", 12, 10);
        keys("rst", 1, 2);
        COST = 3'd4;
        tick();
        COST = '0;
        chk("rst vtran_c5", 32'(VALID_TRAN), 1);
        RST_N = 1'b0;
        tick();
        outs_zero("rst");
        chk("rst ready", 32'(REQ_READY), 0);
        chk("rst rsp_valid", 32'(RSP_VALID), 0);
        RST_N = 1'b1;
        tick();
        chk("rst rsp_after", 32'(RSP_VALID), 0);
        chk("rst vtran_after", 32'(VALID_TRAN), 0);

        // Fresh request after reset: item 19, balance 255, cost 7.
        request("fresh", 19, 255);
        keys("fresh", 1, 9);
        COST = 3'd7;
        tick();
        COST = '0;
        chk("fresh vtran_c5", 32'(VALID_TRAN), 1);
        tick();
        VEND = 1'b1;
        chk("fresh vtran_c6", 32'(VALID_TRAN), 1);
        tick();
        chk("fresh vtran_c7", 32'(VALID_TRAN), 0);
        chk("fresh door_c7", 32'(DOOR_OPEN), 1);
        tick();
        VEND = 1'b0;
        chk("fresh door_c8", 32'(DOOR_OPEN), 1);
        tick();
        chk("fresh door_c9", 32'(DOOR_OPEN), 1);
        tick();
        chk("fresh door_c10", 32'(DOOR_OPEN), 0);
        chk("fresh rsp_c10", 32'(RSP_VALID), 0);
        tick();
        rsp("fresh", 0, 7, 248);
        tick();
        chk("fresh ready_after", 32'(REQ_READY), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
